// File: rtl/vga_sync_gen.sv
// VGA raster timing generator with a per-frame snapshot of the trading-data bus.
// The counters, the sync/video decodes and the snapshot are all registered.
// The decodes are computed from the next-state counter values, so each output
// describes the same (h_cnt, v_cnt) pair that is presented in the same cycle.
module vga_sync_gen #(
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33
) (
   input  logic       clk_25mhz,
   input  logic       rst,
   input  logic [7:0] buy_price_in,
   input  logic [7:0] sell_price_in,
   input  logic [7:0] trade_count_in,
   input  logic [7:0] spread_in,
   input  logic       halt_in,
   output logic [9:0] h_cnt,
   output logic [9:0] v_cnt,
   output logic       video_on,
   output logic       hsync,
   output logic       vsync,
   output logic       frame_start,
   output logic [7:0] buy_price,
   output logic [7:0] sell_price,
   output logic [7:0] trade_count,
   output logic [7:0] spread,
   output logic       halt_signal,
   output logic [7:0] frame_count
);

   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
   localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
   localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
   localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
   localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
   localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
   localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
   localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

   logic [9:0] h_q, h_d;
   logic [9:0] v_q, v_d;
   logic       video_on_q, video_on_d;
   logic       hsync_q, hsync_d;
   logic       vsync_q, vsync_d;
   logic       frame_start_q, frame_start_d;
   logic [7:0] buy_q, buy_d;
   logic [7:0] sell_q, sell_d;
   logic [7:0] trades_q, trades_d;
   logic [7:0] spread_q, spread_d;
   logic       halt_q, halt_d;
   logic [7:0] frames_q, frames_d;
   logic       line_wrap;
   logic       frame_wrap;

   // Next-state counters, decodes of those next-state values, and snapshot capture.
   always_comb begin
      line_wrap  = (h_q == H_LAST);
      frame_wrap = line_wrap && (v_q == V_LAST);

      h_d = line_wrap ? 10'd0 : h_q + 10'd1;
      v_d = v_q;
      if (line_wrap) begin
         v_d = (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
      end

      video_on_d    = (h_d < H_VIS) && (v_d < V_VIS);
      hsync_d       = !((h_d >= HS_FIRST) && (h_d <= HS_LAST));
      vsync_d       = !((v_d >= VS_FIRST) && (v_d <= VS_LAST));
      frame_start_d = (h_d == 10'd0) && (v_d == 10'd0);

      buy_d    = buy_q;
      sell_d   = sell_q;
      trades_d = trades_q;
      spread_d = spread_q;
      halt_d   = halt_q;
      frames_d = frames_q;
      if (frame_wrap) begin
         buy_d    = buy_price_in;
         sell_d   = sell_price_in;
         trades_d = trade_count_in;
         spread_d = spread_in;
         halt_d   = halt_in;
         frames_d = frames_q + 8'd1;
      end
   end

   // State register; reset parks the counters on the last pixel so release is a frame wrap.
   always_ff @(posedge clk_25mhz) begin
      if (rst) begin
         h_q           <= H_LAST;
         v_q           <= V_LAST;
         video_on_q    <= 1'b0;
         hsync_q       <= 1'b1;
         vsync_q       <= 1'b1;
         frame_start_q <= 1'b0;
         buy_q         <= 8'd0;
         sell_q        <= 8'd0;
         trades_q      <= 8'd0;
         spread_q      <= 8'd0;
         halt_q        <= 1'b0;
         frames_q      <= 8'd0;
      end else begin
         h_q           <= h_d;
         v_q           <= v_d;
         video_on_q    <= video_on_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         frame_start_q <= frame_start_d;
         buy_q         <= buy_d;
         sell_q        <= sell_d;
         trades_q      <= trades_d;
         spread_q      <= spread_d;
         halt_q        <= halt_d;
         frames_q      <= frames_d;
      end
   end

   assign h_cnt       = h_q;
   assign v_cnt       = v_q;
   assign video_on    = video_on_q;
   assign hsync       = hsync_q;
   assign vsync       = vsync_q;
   assign frame_start = frame_start_q;
   assign buy_price   = buy_q;
   assign sell_price  = sell_q;
   assign trade_count = trades_q;
   assign spread      = spread_q;
   assign halt_signal = halt_q;
   assign frame_count = frames_q;

endmodule
